// File: rtl/dsp_div_pkg.sv
// Shared types and helpers for the iterative unsigned divider.
package dsp_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Width of an iteration counter that must reach n_width-1.
  function automatic int cnt_width(input int n_width);
    return $clog2(n_width);
  endfunction

endpackage

// File: rtl/dsp_div_step.sv
// One combinational restoring step: shift in a dividend bit, trial-subtract the divisor.
module dsp_div_step #(
  parameter int D_WIDTH = 32
) (
  input  logic [D_WIDTH:0]   pr,
  input  logic               bit_in,
  input  logic [D_WIDTH-1:0] d,
  output logic [D_WIDTH:0]   pr_next,
  output logic               q_bit
);

  logic [D_WIDTH:0] shifted;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = {pr[D_WIDTH-1:0], bit_in};
    pr_next = shifted;
    // A set top bit in pr means the shifted value already exceeds any divisor.
    q_bit   = pr[D_WIDTH] | (shifted >= {1'b0, d});
    if (q_bit) begin
      pr_next = shifted - {1'b0, d};
    end
  end

endmodule

// File: rtl/dsp_div_unsigned_iterative.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock, start/ready/valid handshake.
module dsp_div_unsigned_iterative
  import dsp_div_pkg::*;
#(
  parameter int N_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_WIDTH-1:0] N,
  input  logic [D_WIDTH-1:0] D,
  output logic               ready,
  output logic [N_WIDTH-1:0] Q,
  output logic [D_WIDTH-1:0] R,
  output logic               valid,
  output logic               div_by_zero
);

  localparam int                CNT_W    = cnt_width(N_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_WIDTH - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [N_WIDTH-1:0] dividend;
  logic [D_WIDTH-1:0] divisor;
  logic [D_WIDTH:0]   pr;
  logic [D_WIDTH:0]   pr_next;
  logic               q_bit;
  logic               zero_div;

  dsp_div_step #(.D_WIDTH(D_WIDTH)) u_step (
    .pr      (pr),
    .bit_in  (dividend[N_WIDTH-1]),
    .d       (divisor),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start)           state_next = CALC;
      CALC: if (cnt == CNT_LAST) state_next = DONE;
      DONE:                      state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Divide-by-zero makes a single pass through CALC so its result lands one cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready       <= 1'b1;
      valid       <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      dividend    <= '0;
      divisor     <= '0;
      pr          <= '0;
      zero_div    <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
      valid <= (state_next == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            dividend <= N;
            divisor  <= D;
            pr       <= '0;
            zero_div <= (D == '0);
            cnt      <= (D == '0) ? CNT_LAST : '0;
          end
        end
        CALC: begin
          dividend <= {dividend[N_WIDTH-2:0], q_bit};
          pr       <= pr_next;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (zero_div) begin
              Q           <= '1;
              R           <= dividend[D_WIDTH-1:0];
              div_by_zero <= 1'b1;
            end else begin
              Q           <= {dividend[N_WIDTH-2:0], q_bit};
              R           <= pr_next[D_WIDTH-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_div_unsigned_iterative.sv
// Directed and random checks of the iterative divider against a plain-arithmetic model.
module tb_dsp_div_unsigned_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] N, D, Q, R;
  logic        ready, valid, div_by_zero;

  int checks   = 0;
  int failures = 0;

  dsp_div_unsigned_iterative #(.N_WIDTH(32), .D_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .N           (N),
    .D           (D),
    .ready       (ready),
    .Q           (Q),
    .R           (R),
    .valid       (valid),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_q(input logic [31:0] n, input logic [31:0] d);
    return (d == 0) ? 32'hFFFF_FFFF : n / d;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] n, input logic [31:0] d);
    return (d == 0) ? n : n % d;
  endfunction

  // Waits for ready, presents one request for a single cycle, then scrambles N/D.
  // Returns at the negedge following the accepting edge.
  task automatic issue(input logic [31:0] n, input logic [31:0] d);
    int waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("issue_ready", ready, 1);
    N = n; D = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    N = $urandom; D = $urandom;
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    while (valid !== 1'b1 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] n, input logic [31:0] d);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_q"}, Q, ref_q(n, d));
    check({tag, "_r"}, R, ref_r(n, d));
    check({tag, "_dbz"}, div_by_zero, (d == 0));
    @(negedge clk);
    check({tag, "_pulse"}, valid, 0);
    check({tag, "_ready"}, ready, 1);
  endtask

  initial begin
    int lat;
    int vcount;
    logic [31:0] n, d;
    logic [31:0] bn [3] = '{32'hFFFF_FFFF, 32'd5,  32'hFFFF_FFFF};
    logic [31:0] bd [3] = '{32'd1,         32'd10, 32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; N = '0; D = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_dbz", div_by_zero, 0);

    issue(32'd100, 32'd7);
    check("basic_busy", ready, 0);
    wait_valid(40, lat);
    check("basic_lat", lat, 32);
    check("basic_q14", Q, 14);
    check("basic_r2", R, 2);
    check_result("basic", 32'd100, 32'd7);

    for (int i = 0; i < 3; i++) begin
      issue(bn[i], bd[i]);
      wait_valid(40, lat);
      check($sformatf("edge%0d_lat", i), lat, 32);
      check_result($sformatf("edge%0d", i), bn[i], bd[i]);
    end

    issue(32'd1234, 32'd0);
    wait_valid(40, lat);
    check("dz_lat", lat, 1);
    check("dz_q", Q, 32'hFFFF_FFFF);
    check("dz_r", R, 1234);
    check_result("dz", 32'd1234, 32'd0);

    // A second start mid-calculation must be dropped entirely.
    issue(32'd100, 32'd7);
    repeat (5) @(negedge clk);
    N = 32'd9; D = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(40, lat);
    check("busy_lat", lat + 6, 32);
    check_result("busy", 32'd100, 32'd7);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    check("busy_noqueue", vcount, 0);

    issue(32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_valid", valid, 0);
    check("abort_q", Q, 0);
    check("abort_r", R, 0);
    check("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    check("abort_novalid", vcount, 0);

    for (int i = 0; i < 32; i++) begin
      n = $urandom;
      d = $urandom >> $urandom_range(0, 31);
      if (d == 0) d = 32'd1;
      issue(n, d);
      wait_valid(40, lat);
      check($sformatf("rnd%0d_lat", i), lat, 32);
      check_result($sformatf("rnd%0d", i), n, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
